// File: rtl/sfu_pkg.sv
// rtl/sfu_pkg.sv - shared SFU request types, operation codes and legality helper
package sfu_pkg;

  localparam int SELOP_W = 3;
  localparam int DATA_W  = 32;

  localparam logic [SELOP_W-1:0] SELOP_SIN = 3'd0;
  localparam logic [SELOP_W-1:0] SELOP_COS = 3'd1;
  localparam logic [SELOP_W-1:0] SELOP_EXP = 3'd2;
  localparam logic [SELOP_W-1:0] SELOP_LOG = 3'd3;
  localparam logic [SELOP_W-1:0] SELOP_RSQ = 3'd4;
  localparam logic [SELOP_W-1:0] SELOP_RCP = 3'd5;

  typedef struct packed {
    logic [SELOP_W-1:0] selop;
    logic [DATA_W-1:0]  data;
  } sfu_req_t;

  function automatic logic is_legal_selop(input logic [SELOP_W-1:0] selop);
    return selop <= SELOP_RCP;
  endfunction

endpackage

// File: rtl/sfu_req_fifo.sv
// rtl/sfu_req_fifo.sv - DEPTH-entry request FIFO with occupancy count and flush
module sfu_req_fifo
  import sfu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  sfu_req_t                 entry_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output sfu_req_t                 head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sfu_req_t           mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  // Flush wins over both ends; the caller guarantees push only when not full, pop only when not empty.
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= entry_i;
    end
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/sfu_issue_queue.sv
// rtl/sfu_issue_queue.sv - buffers core SFU requests and issues them under an in-flight credit limit
module sfu_issue_queue
  import sfu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [SELOP_W-1:0]       in_selop_i,
  input  logic [DATA_W-1:0]        in_data_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  output logic [SELOP_W-1:0]       selop_o,
  output logic [DATA_W-1:0]        data_o,
  input  logic                     sfu_ready_i,
  input  logic                     done_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [1:0]               err_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int CR_W  = $clog2(MAX_OUT + 1);

  logic [CNT_W-1:0] count;
  logic [CR_W-1:0]  credits_q, credits_d;
  logic [1:0]       err_q, err_d;
  logic             accept, legal, push, issue;
  sfu_req_t         entry, head;

  assign in_ready_o = (count < CNT_W'(DEPTH));
  assign accept     = in_valid_i && in_ready_o;
  assign legal      = is_legal_selop(in_selop_i);
  assign push       = accept && legal;
  assign valid_o    = (count != '0) && (credits_q != '0);
  // Same condition the SFU controller uses to take the operation.
  assign issue      = valid_o && sfu_ready_i;

  assign entry.selop = in_selop_i;
  assign entry.data  = in_data_i;

  sfu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (entry),
    .pop_i   (issue),
    .flush_i (flush_i),
    .head_o  (head),
    .count_o (count)
  );

  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    if (accept && !legal) err_d[0] = 1'b1;
    case ({issue, done_i})
      2'b10: credits_d = credits_q - 1'b1;
      2'b01: begin
        // A retire with nothing outstanding is a protocol error; credits saturate.
        if (credits_q == CR_W'(MAX_OUT)) err_d[1] = 1'b1;
        else                             credits_d = credits_q + 1'b1;
      end
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits_q <= CR_W'(MAX_OUT);
      err_q     <= '0;
    end else begin
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign selop_o = head.selop;
  assign data_o  = head.data;
  assign count_o = count;
  assign err_o   = err_q;

endmodule
